regfile_wb: RTL and testbench



---
 rtl/y86_pkg.sv | 19 +
 rtl/regfile_bypass.sv | 31 +++
 rtl/regfile_wb.sv | 96 +++++++++
 tb/tb_regfile_wb.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 writeback definitions: status codes, icode constants and the
// all-ones "no register" index helper.
package y86_pkg;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    localparam logic [3:0] ICODE_HALT = 4'h0;
    localparam logic [3:0] ICODE_NOP  = 4'h1;

    function automatic logic [31:0] rnone(input int unsigned aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Per-read-port forwarding mux for same-cycle writeback data.
// Forwarding exists only when REGFILE_BYPASS_EN is defined; otherwise it passes array data.
module regfile_bypass #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 4
) (
    input  logic [REG_AW-1:0] src,
    input  logic [DATA_W-1:0] arr_val,
    input  logic              we_e,
    input  logic [REG_AW-1:0] dst_e,
    input  logic [DATA_W-1:0] val_e,
    input  logic              we_m,
    input  logic [REG_AW-1:0] dst_m,
    input  logic [DATA_W-1:0] val_m,
    output logic [DATA_W-1:0] val
);

`ifdef REGFILE_BYPASS_EN
    // M is checked last so it wins a dual match, same as the array write.
    always_comb begin
        val = arr_val;
        if (we_e && (dst_e == src)) val = val_e;
        if (we_m && (dst_m == src)) val = val_m;
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{src, we_e, dst_e, val_e, we_m, dst_m, val_m};
    assign val = arr_val;
`endif

endmodule

// File: rtl/regfile_wb.sv
// Y86 register file with writeback-stage write ports, sticky halt and a
// saturating retire counter. Optional forwarding via REGFILE_BYPASS_EN.
module regfile_wb
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 15,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        W_stat,
    input  logic [3:0]        W_icode,
    input  logic [REG_AW-1:0] W_dstE,
    input  logic [REG_AW-1:0] W_dstM,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [DATA_W-1:0] W_valM,
    input  logic [REG_AW-1:0] srcA,
    input  logic [REG_AW-1:0] srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic              halted,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam logic [REG_AW-1:0] RNONE   = REG_AW'(rnone(REG_AW));
    localparam int unsigned       NREGS_U = NREGS;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  retire_q, retire_d;

    logic              live;
    logic              we_e, we_m;
    logic [DATA_W-1:0] arr_a, arr_b;

    function automatic logic reg_ok(input logic [REG_AW-1:0] idx);
        return (idx != RNONE) && (32'(idx) < NREGS_U);
    endfunction

    assign live = (W_stat == STAT_AOK) && !halted_q;
    assign we_e = live && reg_ok(W_dstE);
    assign we_m = live && reg_ok(W_dstM);

    always_comb begin
        regs_d = regs_q;
        if (we_e) regs_d[W_dstE] = W_valE;
        if (we_m) regs_d[W_dstM] = W_valM;
    end

    always_comb begin
        halted_d = halted_q || (W_stat != STAT_AOK);
        retire_d = retire_q;
        if (live && (W_icode != ICODE_NOP) && (retire_q != '1))
            retire_d = retire_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q   <= '{default: '0};
            halted_q <= 1'b0;
            retire_q <= '0;
        end else begin
            regs_q   <= regs_d;
            halted_q <= halted_d;
            retire_q <= retire_d;
        end
    end

    always_comb begin
        arr_a = '0;
        arr_b = '0;
        if (reg_ok(srcA)) arr_a = regs_q[srcA];
        if (reg_ok(srcB)) arr_b = regs_q[srcB];
    end

    regfile_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_byp_a (
        .src(srcA), .arr_val(arr_a),
        .we_e(we_e), .dst_e(W_dstE), .val_e(W_valE),
        .we_m(we_m), .dst_m(W_dstM), .val_m(W_valM),
        .val(valA)
    );

    regfile_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_byp_b (
        .src(srcB), .arr_val(arr_b),
        .we_e(we_e), .dst_e(W_dstE), .val_e(W_valE),
        .we_m(we_m), .dst_m(W_dstM), .val_m(W_valM),
        .val(valB)
    );

    assign halted     = halted_q;
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: stimulus queues expected values, a negedge
// monitor pops and compares them. A second instance uses a 4-bit retire counter.
module tb_regfile_wb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] ADR = 3'd3;
    localparam logic [3:0] NOP = 4'h1;
    localparam logic [3:0] OPQ = 4'h6;
    localparam logic [3:0] RN  = 4'hF;

    logic        clk;
    logic        reset;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [3:0]  W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  srcA, srcB;
    logic [63:0] valA, valB, s_valA, s_valB;
    logic        halted, s_halted;
    logic [31:0] retire_cnt;
    logic [3:0]  s_retire_cnt;

    regfile_wb dut (
        .clk(clk), .reset(reset), .W_stat(W_stat), .W_icode(W_icode),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .halted(halted), .retire_cnt(retire_cnt)
    );

    regfile_wb #(.CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .W_stat(W_stat), .W_icode(W_icode),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
        .srcA(srcA), .srcB(srcB), .valA(s_valA), .valB(s_valB),
        .halted(s_halted), .retire_cnt(s_retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned sel;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // sel: 0 valA, 1 valB, 2 halted, 3 retire_cnt, 4 small-counter retire_cnt
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t        e;
            logic [63:0] act;
            e = sb_q.pop_front();
            case (e.sel)
                0:       act = valA;
                1:       act = valB;
                2:       act = {63'd0, halted};
                3:       act = {32'd0, retire_cnt};
                default: act = {60'd0, s_retire_cnt};
            endcase
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", e.name, act, e.exp);
            end
        end
    end

    task automatic push(input int unsigned sel, input logic [63:0] exp, input string name);
        exp_t e;
        e.sel = sel;
        e.exp = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic set_in(input logic [2:0] st, input logic [3:0] ic,
                          input logic [3:0] de, input logic [63:0] ve,
                          input logic [3:0] dm, input logic [63:0] vm,
                          input logic [3:0] sa, input logic [3:0] sb);
        W_stat = st; W_icode = ic;
        W_dstE = de; W_valE = ve;
        W_dstM = dm; W_valM = vm;
        srcA = sa; srcB = sb;
    endtask

    task automatic idle(input logic [3:0] sa, input logic [3:0] sb);
        set_in(AOK, NOP, RN, 64'd0, RN, 64'd0, sa, sb);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        idle(RN, RN);
        tick();
        tick();
        reset = 1'b0;

        idle(4'd0, 4'd14);
        push(0, 64'd0, "reset_valA");
        push(1, 64'd0, "reset_valB");
        push(2, 64'd0, "reset_halted");
        push(3, 64'd0, "reset_cnt");
        push(4, 64'd0, "reset_cnt_small");
        tick();

        set_in(AOK, OPQ, 4'd3, 64'h1234, RN, 64'd0, 4'd0, RN);
        push(0, 64'd0, "wr3_read0");
        tick();

        set_in(AOK, OPQ, 4'd4, 64'h10, 4'd4, 64'h20, 4'd3, RN);
        push(0, 64'h1234, "read3");
        push(3, 64'd1, "cnt_after_wr3");
        tick();

        set_in(AOK, OPQ, 4'd2, 64'hAB, RN, 64'd0, 4'd4, 4'd2);
        push(0, 64'h20, "conflict_reg4");
        push(1, BYP ? 64'hAB : 64'd0, "bypass_valB");
        push(3, 64'd2, "cnt_after_conflict");
        tick();

        set_in(AOK, OPQ, 4'd5, 64'h55, 4'd5, 64'h66, 4'd5, 4'd2);
        push(0, BYP ? 64'h66 : 64'd0, "bypass_m_prio");
        push(1, 64'hAB, "read2");
        push(3, 64'd3, "cnt_after_wr2");
        tick();

        set_in(AOK, OPQ, RN, 64'h99, 4'd14, 64'hFF, 4'd5, RN);
        push(0, 64'h66, "reg5_m_wins");
        push(1, 64'd0, "read_rnone");
        push(3, 64'd4, "cnt_after_wr5");
        tick();

        for (int i = 0; i < 10; i++) begin
            idle(4'd14, RN);
            tick();
        end

        set_in(ADR, OPQ, 4'd1, 64'd5, RN, 64'd0, 4'd14, RN);
        push(0, 64'hFF, "reg14");
        push(1, 64'd0, "rnone_after_bubbles");
        push(3, 64'd5, "cnt_after_bubbles");
        push(2, 64'd0, "halted_before_edge");
        tick();

        set_in(AOK, OPQ, 4'd1, 64'd7, RN, 64'd0, 4'd1, RN);
        push(2, 64'd1, "halted_set");
        push(0, 64'd0, "reg1_not_written_adr");
        push(3, 64'd5, "cnt_frozen_adr");
        tick();

        idle(4'd1, RN);
        push(0, 64'd0, "reg1_not_written_halted");
        push(3, 64'd5, "cnt_frozen_halted");
        push(2, 64'd1, "halted_sticky");
        tick();

        reset = 1'b1;
        set_in(AOK, OPQ, 4'd6, 64'd9, RN, 64'd0, RN, RN);
        tick();
        reset = 1'b0;

        idle(4'd6, 4'd3);
        push(2, 64'd0, "halted_cleared");
        push(3, 64'd0, "cnt_cleared");
        push(0, 64'd0, "reset_beats_write");
        push(1, 64'd0, "reg3_cleared");
        push(4, 64'd0, "cnt_small_cleared");
        tick();

        for (int i = 1; i <= 20; i++) begin
            set_in(AOK, OPQ, RN, 64'd0, RN, 64'd0, RN, RN);
            push(4, (i - 1 > 15) ? 64'd15 : 64'(i - 1), "sat_small");
            push(3, 64'(i - 1), "sat_big");
            tick();
        end
        idle(RN, RN);
        push(4, 64'd15, "sat_small_final");
        push(3, 64'd20, "sat_big_final");
        tick();

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
